// File: rtl/rr_arb_pkg.sv
// Shared types, sizes and the round-robin search used by the 8-way arbiter.
package rr_arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } search_t;

  // First set request scanning upward from ptr, wrapping from the top index to 0.
  // The scan runs from the farthest candidate back to ptr, so the nearest hit is the last one written.
  function automatic search_t rr_search(input logic [N_REQ-1:0] req,
                                        input logic [IDX_W-1:0] ptr);
    search_t          res;
    logic [IDX_W-1:0] cand;
    res = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = ptr + IDX_W'(i);
      if (req[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter_8_decode.sv
// Enabled 3-to-8 one-hot decoder that feeds the registered grant vector.
module onehot_decode_3to8
  import rr_arb_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [N_REQ-1:0] onehot
);

  // Select exactly one line when enabled, none otherwise.
  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for eight requesters with an optional per-ownership hold limit.
module rr_arbiter_8
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             hold_expired
);

  arb_state_t        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              valid_q, valid_d;
  logic              expired_q, expired_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;

  logic [IDX_W-1:0]  next_ptr;
  logic [N_REQ-1:0]  owner_bit;
  logic              hold_hit;
  search_t           srch;

  assign next_ptr  = idx_q + IDX_W'(1);
  assign owner_bit = N_REQ'(1) << idx_q;
  assign hold_hit  = (MAX_HOLD != 0) && (cnt_q == HOLD_W'(MAX_HOLD));

  // Next ownership: acquire from idle, keep while held, hand over on release or hold expiry.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    expired_d = 1'b0;
    srch      = '0;
    case (state_q)
      IDLE: begin
        srch = rr_search(req, ptr_q);
        if (srch.found) begin
          state_d = GRANT;
          idx_d   = srch.idx;
          cnt_d   = HOLD_W'(1);
          valid_d = 1'b1;
        end
      end
      GRANT: begin
        if (!req[idx_q]) begin
          ptr_d = next_ptr;
          srch  = rr_search(req, next_ptr);
          if (srch.found) begin
            idx_d = srch.idx;
            cnt_d = HOLD_W'(1);
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
            cnt_d   = '0;
          end
        end else if (hold_hit) begin
          ptr_d     = next_ptr;
          expired_d = 1'b1;
          cnt_d     = HOLD_W'(1);
          srch      = rr_search(req & ~owner_bit, next_ptr);
          if (srch.found) begin
            idx_d = srch.idx;
          end
        end else if (MAX_HOLD != 0) begin
          cnt_d = cnt_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  onehot_decode_3to8 u_decode (
    .idx    (idx_d),
    .en     (valid_d),
    .onehot (gnt_d)
  );

  // State, pointer, counter and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      expired_q <= 1'b0;
      gnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      expired_q <= expired_d;
      gnt_q     <= gnt_d;
    end
  end

  assign gnt          = gnt_q;
  assign gnt_idx      = idx_q;
  assign gnt_valid    = valid_q;
  assign hold_expired = expired_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8 with a short hold limit.
module tb_rr_arbiter_8;

  localparam int MAXH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       hold_expired;

  int n_checks = 0;
  int n_errors = 0;

  // Reference ownership model: owner -1 means nobody holds the resource.
  int m_owner = -1;
  int m_last  = 0;
  int m_cnt   = 0;
  int m_ptr   = 0;
  bit m_exp   = 1'b0;

  rr_arbiter_8 #(
    .MAX_HOLD (MAXH),
    .HOLD_W   (3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .gnt          (gnt),
    .gnt_idx      (gnt_idx),
    .gnt_valid    (gnt_valid),
    .hold_expired (hold_expired)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  function automatic int find_next(input logic [7:0] r, input int start, input int skip);
    for (int k = 0; k < 8; k++) begin
      int c;
      c = (start + k) % 8;
      if (r[c] && c != skip) return c;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] r, input int cycles);
    req = r;
    repeat (cycles) @(posedge clk);
    #2;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  // Advance the reference model on each rising edge, or clear it on reset.
  always @(posedge clk or negedge rst_n) begin : model_step
    int o, l, c, p, f;
    bit e;
    if (!rst_n) begin
      m_owner <= -1;
      m_last  <= 0;
      m_cnt   <= 0;
      m_ptr   <= 0;
      m_exp   <= 1'b0;
    end else begin
      o = m_owner; l = m_last; c = m_cnt; p = m_ptr; e = 1'b0;
      if (o < 0) begin
        f = find_next(req, p, -1);
        if (f >= 0) begin o = f; l = f; c = 1; end
      end else if (!req[o]) begin
        p = (o + 1) % 8;
        f = find_next(req, p, -1);
        if (f >= 0) begin o = f; l = f; c = 1; end
        else begin o = -1; c = 0; end
      end else if (MAXH != 0 && c == MAXH) begin
        e = 1'b1;
        p = (o + 1) % 8;
        f = find_next(req, p, o);
        if (f < 0) f = o;
        o = f; l = f; c = 1;
      end else if (MAXH != 0) begin
        c = c + 1;
      end
      m_owner <= o;
      m_last  <= l;
      m_cnt   <= c;
      m_ptr   <= p;
      m_exp   <= e;
    end
  end

  // Compare every DUT output against the model midway through each cycle.
  always @(negedge clk) begin : compare
    logic [7:0] eg;
    eg = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
    checkOutput("gnt", 32'(gnt), 32'(eg));
    checkOutput("gnt_idx", 32'(gnt_idx), 32'(m_last));
    checkOutput("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
    checkOutput("hold_expired", 32'(hold_expired), 32'(m_exp));
    checkOutput("onehot", 32'($countones(gnt) <= 1), 32'd1);
  end

  initial begin
    rst_n = 1'b0;
    req   = 8'hFF;

    // Reset held with every requester asking.
    repeat (2) @(posedge clk);
    #2;
    checkOutput("lit_rst_gnt", 32'(gnt), 32'h00);
    checkOutput("lit_rst_valid", 32'(gnt_valid), 32'd0);
    rst_n = 1'b1;
    applyStimulus(8'hFF, 1);
    checkOutput("lit_first_gnt", 32'(gnt), 32'h01);
    checkOutput("lit_first_idx", 32'(gnt_idx), 32'd0);
    applyStimulus(8'h00, 2);

    // Rotation 0 -> 2 -> 7 -> 0.
    doReset();
    applyStimulus(8'h85, 2);
    checkOutput("lit_rot0", 32'(gnt), 32'h01);
    applyStimulus(8'h84, 1);
    checkOutput("lit_rot2", 32'(gnt), 32'h04);
    applyStimulus(8'h85, 1);
    applyStimulus(8'h81, 1);
    checkOutput("lit_rot7", 32'(gnt), 32'h80);
    applyStimulus(8'h85, 1);
    applyStimulus(8'h05, 1);
    checkOutput("lit_rot_wrap", 32'(gnt), 32'h01);
    applyStimulus(8'h00, 2);

    // Hold expiry with two competing requesters.
    doReset();
    applyStimulus(8'h06, 1);
    checkOutput("lit_hold_a", 32'(gnt), 32'h02);
    applyStimulus(8'h06, 3);
    checkOutput("lit_hold_a4", 32'(gnt), 32'h02);
    checkOutput("lit_hold_noexp", 32'(hold_expired), 32'd0);
    applyStimulus(8'h06, 1);
    checkOutput("lit_hold_b", 32'(gnt), 32'h04);
    checkOutput("lit_hold_exp", 32'(hold_expired), 32'd1);
    applyStimulus(8'h06, 4);
    checkOutput("lit_hold_back", 32'(gnt), 32'h02);
    checkOutput("lit_hold_exp2", 32'(hold_expired), 32'd1);
    applyStimulus(8'h00, 2);

    // Sole requester keeps the grant across expiries.
    doReset();
    applyStimulus(8'h08, 4);
    checkOutput("lit_sole_noexp", 32'(hold_expired), 32'd0);
    applyStimulus(8'h08, 1);
    checkOutput("lit_sole_gnt", 32'(gnt), 32'h08);
    checkOutput("lit_sole_exp", 32'(hold_expired), 32'd1);
    applyStimulus(8'h08, 4);
    checkOutput("lit_sole_exp2", 32'(hold_expired), 32'd1);
    applyStimulus(8'h00, 2);

    // Non-owner noise on bit 5 while owner 3 holds.
    doReset();
    applyStimulus(8'h08, 1);
    applyStimulus(8'h28, 1);
    checkOutput("lit_noise_a", 32'(gnt), 32'h08);
    applyStimulus(8'h08, 1);
    checkOutput("lit_noise_b", 32'(gnt), 32'h08);
    applyStimulus(8'h20, 1);
    checkOutput("lit_noise_hand", 32'(gnt), 32'h20);
    applyStimulus(8'h00, 2);

    // Asynchronous reset in the middle of a grant.
    doReset();
    applyStimulus(8'h10, 2);
    checkOutput("lit_async_pre", 32'(gnt), 32'h10);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("lit_async_gnt", 32'(gnt), 32'h00);
    checkOutput("lit_async_valid", 32'(gnt_valid), 32'd0);
    rst_n = 1'b1;
    applyStimulus(8'h10, 1);
    checkOutput("lit_async_regnt", 32'(gnt), 32'h10);
    checkOutput("lit_async_idx", 32'(gnt_idx), 32'd4);
    applyStimulus(8'h00, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
